shift_right_serial: RTL
=======================

# shift_right_serial

Multi-cycle right shifter for the RV32 datapath that executes SRL/SRLI and SRA/SRAI one bit position per clock. It is the complement of the existing combinational single-bit left shift used for branch/jump offsets, and it sits in the ALU's multi-cycle execution path. The CPU control unit stalls on `busy` and writes the result back when `done` is high.

## Interface
- `WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width, equal to log2(WIDTH).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a shift; sampled only in IDLE or DONE.
- `arith`  in  1  1 = arithmetic (SRA), 0 = logical (SRL); captured with `start`.
- `d`  in  WIDTH  operand; captured with `start`.
- `shamt`  in  SHAMT_W  shift amount, 0..31; captured with `start`.
- `q`  out  WIDTH  working/result register; valid when `done` = 1.
- `busy`  out  1  high while shifting.
- `done`  out  1  one-cycle pulse when `q` holds the final result.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with `start` = 1:
  - load `q` <= `d`, count <= `shamt`, mode <= `arith`.
  - Next state is SHIFT if `shamt` != 0, otherwise DONE.
- SHIFT, each cycle:
  - `q` <= {fill, `q`[WIDTH-1:1]}, where fill = mode ? `q`[WIDTH-1] : 0.
  - count <= count - 1.
  - When count = 1 before decrement, next state is DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - If `start` = 1 in this cycle, the new operation is accepted exactly as from IDLE (back-to-back).
  - Otherwise next state is IDLE.
- `start` in SHIFT is ignored; the captured operands are unaffected.
- `d`, `shamt` and `arith` are don't-care outside the cycle in which `start` is accepted.
- After completion, `q` holds the result unchanged until the next accepted `start` reloads it.
- Only the low SHAMT_W bits form the amount; the maximum is 31.
- The arithmetic fill always replicates the captured operand's MSB, because an SRA shift preserves bit WIDTH-1.
- Decoded outputs: `busy` = (state == SHIFT); `done` = (state == DONE).

## Timing
- Reset values: `q` = 0, count = 0, state = IDLE, `busy` = 0, `done` = 0.
- Reset takes effect at the next rising edge regardless of state, including mid-shift. No result is produced for an aborted operation, and no `done` pulse is emitted.
- Reset has priority over `start` in the same cycle.
- Let `start` be accepted at edge E0.
  - `busy` is high in cycles E0+1 .. E0+shamt.
  - `done` is high in cycle E0+shamt+1.
  - Latency is shamt+1 cycles; the range is 1 (shamt = 0) to 32 (shamt = 31).
- For shamt = 0, `busy` never rises and `done` is high in cycle E0+1 with `q` = `d`.
- Throughput: a new `start` can be accepted in the `done` cycle, so there are no idle cycles between operations.
- During SHIFT, `q` shows intermediate values; consumers must qualify `q` with `done`.

## Test plan
- SRL: `d`=0x80000000, `shamt`=4, `arith`=0.
  - Expect `busy` for 4 cycles, then `done` in cycle E0+5 with `q`=0x08000000.
- SRA: `d`=0x80000000, `shamt`=31, `arith`=1.
  - Expect `done` in cycle E0+32 with `q`=0xFFFFFFFF.
  - Repeat with `d`=0x7FFFFFFF; expect `q`=0x00000000.
- Zero shift: `d`=0xDEADBEEF, `shamt`=0, `arith`=1.
  - Expect `busy` never high, and `done` in cycle E0+1 with `q`=0xDEADBEEF.
- Start during busy: issue SRL of 0x0000F000 by 8. Pulse `start` at E0+3 with `d`=0xFFFFFFFF and `shamt`=1.
  - Expect the second `start` to be ignored and `done` at E0+9 with `q`=0x000000F0.
- Reset mid-operation: SRA of 0xF0000000 by 20, then assert `rst` at E0+5.
  - Expect `q`=0, `busy`=0 and state IDLE on the next edge, with no `done` pulse.
  - A following SRL of 0x00000010 by 4 yields `q`=0x00000001 at E'+5.
- Back-to-back: issue SRL 0x00000100 by 8, then assert `start` in its `done` cycle with SRA 0x80000000 by 1.
  - Expect the first result 0x00000001.
  - Expect the second `done` 2 cycles later with `q`=0xC0000000.

Source files
------------

// File: rtl/shift_right_serial.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_serial
// Purpose  : Multi-cycle RV32 right shifter (SRL/SRLI, SRA/SRAI). The operand
//            moves right by one bit position per clock. The ALU control unit
//            stalls on busy and writes the result back while done is high.
// Ports    : clk    - single clock; all state changes on its rising edge
//            rst    - synchronous, active-high reset
//            start  - request a shift; sampled only in IDLE or DONE
//            arith  - 1 = arithmetic (SRA), 0 = logical (SRL); taken with start
//            d      - operand, taken with start
//            shamt  - shift amount (0..2**SHAMT_W-1), taken with start
//            q      - working/result register; final value valid when done = 1
//            busy   - high while shifting
//            done   - one-cycle pulse when q holds the final result
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_serial #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   d,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done
);

    // State encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_count_zero = '0;
    localparam logic [SHAMT_W-1:0] c_count_one  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    // Registered state
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_q;
    logic [SHAMT_W-1:0] r_count;
    logic               r_mode;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [SHAMT_W-1:0] w_count_nxt;
    logic               w_mode_nxt;
    logic               w_accept;
    logic               w_fill;

    // A new request is only taken when no shift is in flight; accepting it in
    // DONE gives back-to-back operation with no idle cycle in between.
    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    // The shifted-in bit. For SRA, bit WIDTH-1 of the working register never
    // changes during the shift, so it always equals the captured operand's MSB.
    assign w_fill = r_mode & r_q[WIDTH-1];

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;

        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_q_nxt     = d;
                    w_count_nxt = shamt;
                    w_mode_nxt  = arith;
                    // A zero shift needs no SHIFT cycle: the operand is already the result.
                    w_state_nxt = (shamt != c_count_zero) ? c_st_shift : c_st_done;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end

            c_st_shift: begin
                w_q_nxt     = {w_fill, r_q[WIDTH-1:1]};
                w_count_nxt = r_count - c_count_one;
                // The last remaining position is being shifted in this cycle.
                if (r_count == c_count_one) begin
                    w_state_nxt = c_st_done;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_q     <= '0;
            r_count <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_count <= w_count_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Outputs are decoded directly from flops, so they carry no combinational
    // path from the inputs.
    assign q    = r_q;
    assign busy = (r_state == c_st_shift);
    assign done = (r_state == c_st_done);

endmodule
`default_nettype wire
